// File: rtl/alu.sv
// alu: registered 32-bit ALU (AND/OR/ADD/SUB/SLT/NOR) with zero, overflow and carry flags
module alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  ALUOp,
  output logic [31:0] R,
  output logic        ALUz,
  output logic        V,
  output logic        C
);
  logic [32:0] add_s, sub_s;
  logic        add_v, sub_v, slt;
  logic [31:0] nr;
  logic        nv, nc;
  always_comb begin
    add_s = {1'b0, A} + {1'b0, B};
    sub_s = {1'b0, A} + {1'b0, ~B} + 33'd1;
    add_v = (A[31] == B[31]) && (add_s[31] != A[31]);
    sub_v = (A[31] != B[31]) && (sub_s[31] != A[31]);
    slt   = sub_s[31] ^ sub_v;
    nr = ALUOp == 4'b0000 ? A & B :
         ALUOp == 4'b0001 ? A | B :
         ALUOp == 4'b0010 ? add_s[31:0] :
         ALUOp == 4'b0110 ? sub_s[31:0] :
         ALUOp == 4'b0111 ? {31'd0, slt} :
         ALUOp == 4'b1100 ? ~(A | B) : 32'd0;
    nv = ALUOp == 4'b0010 ? add_v : ALUOp == 4'b0110 ? sub_v : 1'b0;
    nc = ALUOp == 4'b0010 ? add_s[32] : ALUOp == 4'b0110 ? sub_s[32] : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      R    <= 32'd0;
      ALUz <= 1'b1;
      V    <= 1'b0;
      C    <= 1'b0;
    end else begin
      R    <= nr;
      ALUz <= nr == 32'd0;
      V    <= nv;
      C    <= nc;
    end
  end
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed and randomized self-checking bench for alu against an arithmetic reference model
module tb_alu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic [3:0]  op;
  logic [31:0] r;
  logic        z, v, c;
  int          tests = 0;
  int          fails = 0;

  alu dut (.clk(clk), .rst_n(rst_n), .A(a), .B(b), .ALUOp(op), .R(r), .ALUz(z), .V(v), .C(c));

  always #5 clk = ~clk;

  task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] er, output logic ez, output logic ev, output logic ec);
    longint sx, sy, d;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    er = 32'd0; ev = 1'b0; ec = 1'b0;
    case (o)
      4'b0000: er = x & y;
      4'b0001: er = x | y;
      4'b1100: er = ~(x | y);
      4'b0010: begin
        d  = sx + sy;
        er = 32'(d);
        ev = d > 64'sd2147483647 || d < -64'sd2147483648;
        ec = (longint'(x) + longint'(y)) > 64'sd4294967295;
      end
      4'b0110: begin
        d  = sx - sy;
        er = 32'(d);
        ev = d > 64'sd2147483647 || d < -64'sd2147483648;
        ec = x >= y;
      end
      4'b0111: er = (sx < sy) ? 32'd1 : 32'd0;
      default: er = 32'd0;
    endcase
    ez = er == 32'd0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] er, input logic ez,
                            input logic ev, input logic ec);
    check({tag, ".R"}, r, er);
    check({tag, ".Z"}, {31'd0, z}, {31'd0, ez});
    check({tag, ".V"}, {31'd0, v}, {31'd0, ev});
    check({tag, ".C"}, {31'd0, c}, {31'd0, ec});
  endtask

  task automatic step(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic        ez, ev, ec;
    model(o, x, y, er, ez, ev, ec);
    step(o, x, y);
    expect_out(tag, er, ez, ev, ec);
  endtask

  initial begin
    logic [3:0]  ops [7] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000};
    logic [3:0]  o;
    logic [31:0] x, y;
    rst_n = 1'b0;
    step(4'b0010, 32'hFFFFFFFF, 32'h1);
    expect_out("reset", 32'd0, 1'b1, 1'b0, 1'b0);
    step(4'b0001, 32'hDEADBEEF, 32'h12345678);
    expect_out("reset_prio", 32'd0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(4'b0010, 32'h7FFFFFFF, 32'h1);
    expect_out("add_ovf", 32'h80000000, 1'b0, 1'b1, 1'b0);
    run("add_carry", 4'b0010, 32'hFFFFFFFF, 32'h1);
    step(4'b0110, 32'd5, 32'd5);
    expect_out("sub_eq", 32'd0, 1'b1, 1'b0, 1'b1);
    step(4'b0110, 32'h80000000, 32'h1);
    expect_out("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
    run("sub_borrow", 4'b0110, 32'd3, 32'd7);
    step(4'b0111, 32'hFFFFFFFF, 32'd1);
    expect_out("slt_neg", 32'd1, 1'b0, 1'b0, 1'b0);
    step(4'b0111, 32'h80000000, 32'h7FFFFFFF);
    expect_out("slt_ovf", 32'd1, 1'b0, 1'b0, 1'b0);
    step(4'b0111, 32'd3, 32'd3);
    expect_out("slt_eq", 32'd0, 1'b1, 1'b0, 1'b0);
    run("slt_rev", 4'b0111, 32'h7FFFFFFF, 32'h80000000);
    step(4'b0000, 32'hF0F0F0F0, 32'h0F0F00FF);
    expect_out("and", 32'h000000F0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 32'hF0F0F0F0, 32'h0F0F00FF);
    expect_out("or", 32'hFFFFF0FF, 1'b0, 1'b0, 1'b0);
    step(4'b1100, 32'hF0F0F0F0, 32'h0F0F00FF);
    expect_out("nor", 32'h00000F00, 1'b0, 1'b0, 1'b0);
    step(4'b1111, 32'h7FFFFFFF, 32'h1);
    expect_out("undef_f", 32'd0, 1'b1, 1'b0, 1'b0);
    run("undef_3", 4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF);
    for (int i = 0; i < 100; i++) begin
      o = (i % 9 == 8) ? 4'($urandom) : ops[$urandom_range(6, 0)];
      x = $urandom;
      y = (i % 4 == 0) ? x : $urandom;
      if (i % 5 == 1) x = {x[31], 31'h7FFFFFFF & {31{x[0]}}};
      if (i == 50) begin
        rst_n = 1'b0;
        step(o, x, y);
        expect_out("rand_rst", 32'd0, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b1;
      end else begin
        run("rand", o, x, y);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
